// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: divides i_clk down to a pixel strobe and
// produces registered sync, active, x/y, event pulses and a frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 10,
  parameter int FW       = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_pix_stb,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_frame_end,
  output logic [FW-1:0] o_frame_cnt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(H_FP + H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_FP + V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CW-1:0] H_BLANK   = CW'(H_FP + H_SYNC + H_BP);
  localparam logic [CW-1:0] V_BLANK   = CW'(V_FP + V_SYNC + V_BP);
  localparam logic [CW-1:0] HS_START  = CW'(H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_FP + V_SYNC);
  localparam logic          H_ON      = (H_POL != 0);
  localparam logic          V_ON      = (V_POL != 0);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          pix_stb_q, pix_stb_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          active_q, active_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_end_q, frame_end_d;
  logic          tick;

  // Outputs are computed from the *next* position so they change on the same
  // edge as the counters and never lag the position they describe.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    tick        = (div_q == DIV_LAST);
    div_d       = tick ? '0 : div_q + DW'(1);
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d         = '0;
          frame_cnt_d = frame_cnt_q + FW'(1);
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end

    pix_stb_d     = tick;
    hsync_d       = (h_d >= HS_START && h_d < HS_END) ? H_ON : ~H_ON;
    vsync_d       = (v_d >= VS_START && v_d < VS_END) ? V_ON : ~V_ON;
    active_d      = (h_d >= H_BLANK) && (v_d >= V_BLANK);
    x_d           = active_d ? h_d - H_BLANK : '0;
    y_d           = active_d ? v_d - V_BLANK : '0;
    line_start_d  = tick && (h_d == '0);
    frame_start_d = line_start_d && (v_d == '0);
    frame_end_d   = tick && (h_d == H_LAST) && (v_d == V_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_cnt_q   <= '0;
      pix_stb_q     <= 1'b0;
      hsync_q       <= ~H_ON;
      vsync_q       <= ~V_ON;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_cnt_q   <= frame_cnt_d;
      pix_stb_q     <= pix_stb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign o_pix_stb     = pix_stb_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_active      = active_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_end   = frame_end_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes (default 640x480, a medium mode, a tiny
// CLK_DIV=1 mode) compared every cycle against a cycle-count arithmetic model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int hp, vp, div, fw;
  } prm_t;

  typedef struct packed {
    logic        stb, hs, vs, act;
    logic [9:0]  x, y;
    logic        ls, fs, fe;
    logic [15:0] fc;
  } obs_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic        stb [3], hs [3], vs [3], act [3], ls [3], fs [3], fe [3];
  logic [9:0]  x [3], y [3];
  logic [15:0] fc0;
  logic [2:0]  fc1;
  logic [1:0]  fc2;
  obs_t        obs [3];

  longint      cyc [3];
  int          hold [3];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .i_clk(clk), .i_rst_n(rst_n[0]), .o_pix_stb(stb[0]), .o_hsync(hs[0]),
    .o_vsync(vs[0]), .o_active(act[0]), .o_x(x[0]), .o_y(y[0]),
    .o_line_start(ls[0]), .o_frame_start(fs[0]), .o_frame_end(fe[0]),
    .o_frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(2),
    .H_POL(1), .V_POL(0), .CLK_DIV(3), .CW(10), .FW(3)
  ) u_med (
    .i_clk(clk), .i_rst_n(rst_n[1]), .o_pix_stb(stb[1]), .o_hsync(hs[1]),
    .o_vsync(vs[1]), .o_active(act[1]), .o_x(x[1]), .o_y(y[1]),
    .o_line_start(ls[1]), .o_frame_start(fs[1]), .o_frame_end(fe[1]),
    .o_frame_cnt(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .CLK_DIV(1), .CW(10), .FW(2)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n[2]), .o_pix_stb(stb[2]), .o_hsync(hs[2]),
    .o_vsync(vs[2]), .o_active(act[2]), .o_x(x[2]), .o_y(y[2]),
    .o_line_start(ls[2]), .o_frame_start(fs[2]), .o_frame_end(fe[2]),
    .o_frame_cnt(fc2)
  );

  assign obs[0] = {stb[0], hs[0], vs[0], act[0], x[0], y[0], ls[0], fs[0], fe[0], fc0};
  assign obs[1] = {stb[1], hs[1], vs[1], act[1], x[1], y[1], ls[1], fs[1], fe[1], 13'd0, fc1};
  assign obs[2] = {stb[2], hs[2], vs[2], act[2], x[2], y[2], ls[2], fs[2], fe[2], 14'd0, fc2};

  function automatic prm_t get_prm(input int i);
    prm_t p;
    case (i)
      0:       p = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 4, 16};
      1:       p = '{20, 2, 3, 4, 6, 2, 1, 2, 1, 0, 3, 3};
      default: p = '{8, 1, 1, 2, 4, 1, 1, 1, 1, 1, 1, 2};
    endcase
    return p;
  endfunction

  // Expected outputs after 'c' rising edges out of reset: position is simply the
  // number of elapsed pixel periods folded onto the raster.
  function automatic obs_t model(input prm_t p, input longint c);
    obs_t   e;
    longint ht, vt, hbl, vbl, ticks, pos, h, v;
    ht    = p.hf + p.hs + p.hb + p.ha;
    vt    = p.vf + p.vs + p.vb + p.va;
    hbl   = p.hf + p.hs + p.hb;
    vbl   = p.vf + p.vs + p.vb;
    ticks = c / p.div;
    pos   = ticks % (ht * vt);
    h     = pos % ht;
    v     = pos / ht;
    e.stb = (c > 0) && (c % p.div == 0);
    e.hs  = (h >= p.hf && h < p.hf + p.hs) ? (p.hp != 0) : (p.hp == 0);
    e.vs  = (v >= p.vf && v < p.vf + p.vs) ? (p.vp != 0) : (p.vp == 0);
    e.act = (h >= hbl) && (v >= vbl);
    e.x   = e.act ? 10'(h - hbl) : 10'd0;
    e.y   = e.act ? 10'(v - vbl) : 10'd0;
    e.ls  = e.stb && (h == 0);
    e.fs  = e.stb && (h == 0) && (v == 0);
    e.fe  = e.stb && (h == ht - 1) && (v == vt - 1);
    e.fc  = 16'((ticks / (ht * vt)) % (64'd1 << p.fw));
    return e;
  endfunction

  task automatic check(input string tag, input int unsigned o, input int unsigned e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check_inst(input int i);
    obs_t e, o;
    e = model(get_prm(i), cyc[i]);
    o = obs[i];
    check($sformatf("m%0d c%0d pix_stb", i, cyc[i]), o.stb, e.stb);
    check($sformatf("m%0d c%0d hsync", i, cyc[i]), o.hs, e.hs);
    check($sformatf("m%0d c%0d vsync", i, cyc[i]), o.vs, e.vs);
    check($sformatf("m%0d c%0d active", i, cyc[i]), o.act, e.act);
    check($sformatf("m%0d c%0d x", i, cyc[i]), o.x, e.x);
    check($sformatf("m%0d c%0d y", i, cyc[i]), o.y, e.y);
    check($sformatf("m%0d c%0d line_start", i, cyc[i]), o.ls, e.ls);
    check($sformatf("m%0d c%0d frame_start", i, cyc[i]), o.fs, e.fs);
    check($sformatf("m%0d c%0d frame_end", i, cyc[i]), o.fe, e.fe);
    check($sformatf("m%0d c%0d frame_cnt", i, cyc[i]), o.fc, e.fc);
  endtask

  initial begin
    rst_n = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cyc[i]  = 0;
      hold[i] = 0;
    end

    // Reset values, then release on a falling edge.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_inst(i);
    rst_n = 3'b111;

    for (int n = 0; n < 13000; n++) begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) if (rst_n[i]) cyc[i]++;
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_inst(i);

      // Directed mid-line reset of the default mode, then random resets late in the run.
      for (int i = 0; i < 3; i++) begin
        if (!rst_n[i]) begin
          if (hold[i] == 0) rst_n[i] = 1'b1;
          else hold[i]--;
        end else if ((i == 0 && n == 5000) ||
                     (n >= 9000 && $urandom_range(0, 399) == 0)) begin
          rst_n[i] = 1'b0;
          cyc[i]   = 0;
          hold[i]  = $urandom_range(0, 4);
          #1;
          check_inst(i);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
